// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational same-cycle lookup, one update per clock, no backpressure.
// Update/flush land at the rising edge; lookups see the pre-edge contents (no bypass).
module branch_target_buffer #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int CNT_W   = 32
) (
  input  logic             btb_clk,
  input  logic             btb_rst_n,
  input  logic             btb_lookup_valid,
  input  logic [PC_W-1:0]  btb_lookup_pc,
  output logic             btb_pred_hit,
  output logic             btb_pred_taken,
  output logic [PC_W-1:0]  btb_pred_target,
  input  logic             btb_upd_valid,
  input  logic [PC_W-1:0]  btb_upd_pc,
  input  logic             btb_upd_taken,
  input  logic [PC_W-1:0]  btb_upd_target,
  output logic [1:0]       btb_upd_cur_pred,
  input  logic [1:0]       btb_upd_new_pred,
  input  logic             btb_flush,
  output logic [CNT_W-1:0] btb_lookup_count,
  output logic [CNT_W-1:0] btb_hit_count
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [1:0]         r_cnt    [ENTRIES];
  logic [CNT_W-1:0]   r_lookup_count;
  logic [CNT_W-1:0]   r_hit_count;

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_unused;

  assign w_lk_idx  = btb_lookup_pc[IDX_W+1:2];
  assign w_lk_tag  = btb_lookup_pc[PC_W-1:IDX_W+2];
  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_upd_idx = btb_upd_pc[IDX_W+1:2];
  assign w_upd_tag = btb_upd_pc[PC_W-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  // Word-aligned PCs: the byte-offset bits carry no information.
  assign w_unused  = ^{btb_lookup_pc[1:0], btb_upd_pc[1:0]};

  assign btb_pred_hit     = w_lk_hit && btb_lookup_valid;
  assign btb_pred_taken   = btb_pred_hit && r_cnt[w_lk_idx][1];
  assign btb_pred_target  = btb_pred_hit ? r_target[w_lk_idx] : '0;
  assign btb_upd_cur_pred = btb_upd_valid ? r_cnt[w_upd_idx] : 2'b00;

  always_ff @(posedge btb_clk or negedge btb_rst_n) begin
    if (!btb_rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= 2'b00;
      end
    end else if (btb_flush) begin
      r_valid <= '0;
    end else if (btb_upd_valid) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx] <= btb_upd_new_pred;
        if (btb_upd_taken) begin
          r_target[w_upd_idx] <= btb_upd_target;
        end
      end else if (btb_upd_taken) begin
        // Allocation evicts whatever aliased here; fresh entries start weakly taken.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= btb_upd_target;
        r_cnt[w_upd_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge btb_clk or negedge btb_rst_n) begin
    if (!btb_rst_n) begin
      r_lookup_count <= '0;
      r_hit_count    <= '0;
    end else begin
      if (btb_lookup_valid) begin
        r_lookup_count <= r_lookup_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (btb_pred_hit) begin
        r_hit_count <= r_hit_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign btb_lookup_count = r_lookup_count;
  assign btb_hit_count    = r_hit_count;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer with an external 2-bit hysteresis prediction FSM.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  upd_cur_pred;
  logic [1:0]  upd_new_pred;
  logic        flush;
  logic [31:0] lookup_count;
  logic [31:0] hit_count;

  int errors = 0;
  int checks = 0;
  int exp_lk = 0;
  int exp_hits = 0;

  always #5 clk = ~clk;

  branch_target_buffer dut (
    .btb_clk          (clk),
    .btb_rst_n        (rst_n),
    .btb_lookup_valid (lk_valid),
    .btb_lookup_pc    (lk_pc),
    .btb_pred_hit     (pred_hit),
    .btb_pred_taken   (pred_taken),
    .btb_pred_target  (pred_target),
    .btb_upd_valid    (upd_valid),
    .btb_upd_pc       (upd_pc),
    .btb_upd_taken    (upd_taken),
    .btb_upd_target   (upd_target),
    .btb_upd_cur_pred (upd_cur_pred),
    .btb_upd_new_pred (upd_new_pred),
    .btb_flush        (flush),
    .btb_lookup_count (lookup_count),
    .btb_hit_count    (hit_count)
  );

  // Hysteresis FSM: a wrong guess from a weak state jumps to the strong opposite state.
  function automatic logic [1:0] fsm_next(input logic [1:0] c, input logic t);
    case (c)
      2'b00:   fsm_next = t ? 2'b01 : 2'b00;
      2'b01:   fsm_next = t ? 2'b11 : 2'b00;
      2'b10:   fsm_next = t ? 2'b11 : 2'b00;
      default: fsm_next = t ? 2'b11 : 2'b10;
    endcase
  endfunction

  always_comb upd_new_pred = fsm_next(upd_cur_pred, upd_taken);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic fl);
    lk_valid = lv; lk_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; flush = fl;
  endtask

  task automatic chk_out(input string tag, input logic eh, input logic et,
                         input logic [31:0] etgt, input logic [1:0] ecp);
    chk({tag, " hit"},    32'(pred_hit),     32'(eh));
    chk({tag, " taken"},  32'(pred_taken),   32'(et));
    chk({tag, " target"}, pred_target,       etgt);
    chk({tag, " curpred"},32'(upd_cur_pred), 32'(ecp));
  endtask

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        fl;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
    logic [1:0]  ecp;
  } vec_t;

  vec_t vecs[22];

  initial begin
    // lookup | update | flush | expected hit,taken,target,cur_pred (pre-edge)
    vecs[0]  = '{1'b1,32'h40,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b0,1'b0,32'h0,  2'b00};
    vecs[1]  = '{1'b0,32'h0,    1'b1,32'h40,  1'b1,32'h100, 1'b0, 1'b0,1'b0,32'h0,  2'b00};
    vecs[2]  = '{1'b1,32'h40,   1'b1,32'h40,  1'b0,32'h0,   1'b0, 1'b1,1'b1,32'h100,2'b10};
    vecs[3]  = '{1'b1,32'h40,   1'b1,32'h40,  1'b1,32'h100, 1'b0, 1'b1,1'b0,32'h100,2'b00};
    vecs[4]  = '{1'b1,32'h40,   1'b1,32'h40,  1'b1,32'h100, 1'b0, 1'b1,1'b0,32'h100,2'b01};
    vecs[5]  = '{1'b1,32'h40,   1'b1,32'h40,  1'b0,32'h0,   1'b0, 1'b1,1'b1,32'h100,2'b11};
    vecs[6]  = '{1'b1,32'h40,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b1,1'b1,32'h100,2'b00};
    vecs[7]  = '{1'b1,32'h80,   1'b1,32'h80,  1'b1,32'h300, 1'b0, 1'b0,1'b0,32'h0,  2'b10};
    vecs[8]  = '{1'b1,32'h40,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b0,1'b0,32'h0,  2'b00};
    vecs[9]  = '{1'b1,32'h80,   1'b1,32'h440, 1'b0,32'h500, 1'b0, 1'b1,1'b1,32'h300,2'b10};
    vecs[10] = '{1'b1,32'h80,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b1,1'b1,32'h300,2'b00};
    vecs[11] = '{1'b0,32'h0,    1'b1,32'h40,  1'b1,32'h100, 1'b0, 1'b0,1'b0,32'h0,  2'b10};
    vecs[12] = '{1'b1,32'h40,   1'b1,32'h40,  1'b1,32'h200, 1'b0, 1'b1,1'b1,32'h100,2'b10};
    vecs[13] = '{1'b1,32'h40,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b1,1'b1,32'h200,2'b00};
    vecs[14] = '{1'b0,32'h40,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b0,1'b0,32'h0,  2'b00};
    vecs[15] = '{1'b1,32'h44,   1'b1,32'h44,  1'b1,32'h600, 1'b0, 1'b0,1'b0,32'h0,  2'b00};
    vecs[16] = '{1'b1,32'h44,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b1,1'b1,32'h600,2'b00};
    vecs[17] = '{1'b1,32'h40,   1'b1,32'h1000,1'b1,32'h700, 1'b1, 1'b1,1'b1,32'h200,2'b11};
    vecs[18] = '{1'b1,32'h40,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b0,1'b0,32'h0,  2'b00};
    vecs[19] = '{1'b1,32'h1000, 1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b0,1'b0,32'h0,  2'b00};
    vecs[20] = '{1'b1,32'h44,   1'b0,32'h0,   1'b0,32'h0,   1'b0, 1'b0,1'b0,32'h0,  2'b00};
    vecs[21] = '{1'b0,32'h0,    1'b1,32'h40,  1'b0,32'h0,   1'b0, 1'b0,1'b0,32'h0,  2'b11};

    // Reset state with activity presented on the inputs.
    rst_n = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0);
    #3;
    chk_out("reset", 1'b0, 1'b0, 32'h0, 2'b00);
    chk("reset lookup_count", lookup_count, 32'h0);
    chk("reset hit_count",    hit_count,    32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].fl);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].eh, vecs[i].et, vecs[i].etgt, vecs[i].ecp);
      chk($sformatf("v%0d lookup_count", i), lookup_count, 32'(exp_lk));
      chk($sformatf("v%0d hit_count", i),    hit_count,    32'(exp_hits));
      exp_lk   += int'(vecs[i].lv);
      exp_hits += int'(vecs[i].eh);
    end

    // Mid-stream asynchronous reset drops state and the in-flight update.
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 32'h48, 1'b1, 32'h800, 1'b0);
    #1;
    chk("rst seq alloc curpred", 32'(upd_cur_pred), 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h48, 1'b1, 32'h48, 1'b1, 32'h900, 1'b0);
    #1;
    chk_out("rst seq pre", 1'b1, 1'b1, 32'h800, 2'b10);
    chk("rst seq pre lookup_count", lookup_count, 32'(exp_lk));
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("rst async", 1'b0, 1'b0, 32'h0, 2'b00);
    chk("rst async lookup_count", lookup_count, 32'h0);
    chk("rst async hit_count",    hit_count,    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h48, 1'b1, 32'h48, 1'b1, 32'hA00, 1'b0);
    #1;
    chk_out("post rst", 1'b0, 1'b0, 32'h0, 2'b00);
    chk("post rst lookup_count", lookup_count, 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h48, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    chk_out("first upd", 1'b1, 1'b1, 32'hA00, 2'b00);
    chk("first upd lookup_count", lookup_count, 32'h1);
    chk("first upd hit_count",    hit_count,    32'h0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer holding per-entry valid bit, tag, target address and 2-bit prediction counter. The fetch stage queries it each cycle for a same-cycle taken/target prediction. The resolve stage sends branch outcomes to it. On updates it drives the stored counter to the external 2-bit prediction FSM and writes back the FSM's new-prediction result.

## Interface
Parameters:
- PC_W, 32, instruction address width; instructions are word aligned, so pc[1:0] is ignored.
- ENTRIES, 16, number of entries; power of two, at least 2.
- IDX_W, $clog2(ENTRIES), index width; index = pc[IDX_W+1:2], tag = pc[PC_W-1:IDX_W+2].
- CNT_W, 32, width of the statistics counters.

Ports:
- btb_clk  in  1  clock; all state updates on its rising edge.
- btb_rst_n  in  1  asynchronous, active-low reset.
- btb_lookup_valid  in  1  fetch is presenting btb_lookup_pc this cycle.
- btb_lookup_pc  in  PC_W  fetch PC.
- btb_pred_hit  out  1  btb_lookup_pc matches a valid entry.
- btb_pred_taken  out  1  btb_pred_hit AND stored counter bit 1.
- btb_pred_target  out  PC_W  stored target of the matched entry; 0 when no hit.
- btb_upd_valid  in  1  resolve stage reports a branch outcome this cycle.
- btb_upd_pc  in  PC_W  PC of the resolved branch.
- btb_upd_taken  in  1  actual branch outcome.
- btb_upd_target  in  PC_W  actual target address.
- btb_upd_cur_pred  out  2  counter of the entry indexed by btb_upd_pc; drives the prediction FSM's current-prediction input.
- btb_upd_new_pred  in  2  FSM result for btb_upd_cur_pred and btb_upd_taken.
- btb_flush  in  1  synchronous invalidate of all entries.
- btb_lookup_count  out  CNT_W  number of lookups since reset.
- btb_hit_count  out  CNT_W  number of lookup hits since reset.

## Operation
- Storage per entry: valid, tag (PC_W-IDX_W-2 bits), target (PC_W), cnt (2 bits). Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Lookup path is purely combinational.
  - hit = valid[idx] AND tag[idx] == lookup tag.
  - btb_pred_hit = hit AND btb_lookup_valid.
  - btb_pred_taken and btb_pred_target are 0 whenever btb_pred_hit = 0.
- btb_upd_cur_pred = cnt[upd idx] when btb_upd_valid = 1, otherwise 00. It is combinational and does not depend on a tag match.
- Update, applied at the clock edge when btb_upd_valid = 1:
  - Tag hit: cnt <= btb_upd_new_pred. If btb_upd_taken, also target <= btb_upd_target.
  - Tag miss, taken: allocate by overwriting the entry. Set valid = 1, tag = upd tag, target = btb_upd_target, cnt = 10. The FSM result is ignored.
  - Tag miss, not taken: no state change.
- Flush: when btb_flush = 1, all valid bits clear at the edge. Tags, targets and counters are left as they are. Flush has priority over a same-cycle update, so that update is dropped.
- Statistics:
  - btb_lookup_count increments on each cycle with btb_lookup_valid = 1.
  - btb_hit_count increments on each cycle with btb_pred_hit = 1.
  - Both wrap modulo 2^CNT_W and are not cleared by flush.

## Timing
- Lookup latency is 0 cycles: predictions are valid in the same cycle as btb_lookup_pc.
- An update written at edge N is visible to lookups from cycle N+1 on.
- Lookup and update on the same index in the same cycle: the lookup returns the pre-edge contents. There is no bypass.
- Back-to-back updates to the same index on consecutive cycles: the second update sees the first update's result on btb_upd_cur_pred.
- Reset (btb_rst_n low, asynchronous):
  - All valid bits, counters, tags, targets and statistics counters go to 0.
  - Consequently btb_pred_hit, btb_pred_taken and btb_pred_target read 0, and btb_upd_cur_pred reads 00.
  - Reset asserted mid-operation discards any in-flight update at once.
  - Deassertion is synchronised externally; the first update is accepted at the first rising edge after release.
- Aliasing: two PCs with the same index and different tags evict each other on each taken allocation.

## Test plan
- Reset, then lookup 0x0000_0040 → hit = 0, taken = 0, target = 0, lookup_count = 1, hit_count = 0.
- Taken update pc = 0x40, target 0x100 on a cold entry → next cycle, lookup 0x40 gives hit = 1, taken = 1, target = 0x100, and cur_pred = 10 on an update to that pc.
- Counter walk on pc = 0x40 with the FSM attached:
  - not-taken from 10 → 00, then lookup taken = 0 with hit still 1;
  - taken → 01;
  - taken → 11;
  - not-taken → 10;
  - at each step, lookup taken equals bit 1 of the new counter.
- Aliasing, ENTRIES = 16: a taken update at 0x40 then a taken update at 0x80 (same index 0, different tag) → lookup 0x40 misses, lookup 0x80 hits with the new target. A not-taken update at 0x440 on a miss leaves the entry unchanged.
- Same cycle: lookup 0x40 plus an update to 0x40 with a new target 0x200 → the lookup shows the old target; the next cycle shows 0x200.
- Flush:
  - btb_flush together with a taken update on a cold pc → all lookups miss afterwards and the update is not allocated.
  - Asserting btb_rst_n low mid-stream → all outputs and counters read 0 immediately, before the next clock edge.
